// File: rtl/gfx_pkg.sv
// gfx_pkg: shared graphics constants for the track/sprite map read path
package gfx_pkg;
  localparam int REQ_FORWARD = 0;
  localparam int REQ_MINIMAP = 1;
  localparam int REQ_RACER = 2;
  localparam int TRACK_ADDR_WIDTH = 16;
  localparam int TRACK_DATA_WIDTH = 12;
  localparam int TRACK_READ_LATENCY = 2;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: one-hot find-first-set starting just after ptr_i, wrapping around
module rr_picker #(
  parameter int N = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);
  logic [PW-1:0] cur;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found_o = 1'b0;
    cur = ptr_i;
    for (int k = 0; k < N; k++) begin
      cur = (cur == PW'(N - 1)) ? '0 : cur + 1'b1;
      if (!found_o && req_i[cur]) begin
        gnt_o[cur] = 1'b1;
        idx_o = cur;
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/track_mem_arbiter.sv
// track_mem_arbiter: shares the map BRAM read port; starved requesters first, then the
// fixed-priority requester, then round-robin, with a tagged fixed-latency response path.
module track_mem_arbiter
  import gfx_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PRIO_REQ = REQ_FORWARD,
  parameter int ADDR_WIDTH = TRACK_ADDR_WIDTH,
  parameter int DATA_WIDTH = TRACK_DATA_WIDTH,
  parameter int READ_LATENCY = TRACK_READ_LATENCY,
  parameter int MAX_WAIT = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_REQ-1:0]                   req_valid_in,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_in,
  output logic [NUM_REQ-1:0]                   req_ready_out,
  output logic                                 mem_en_out,
  output logic [ADDR_WIDTH-1:0]                mem_addr_out,
  input  logic [DATA_WIDTH-1:0]                mem_data_in,
  output logic [NUM_REQ-1:0]                   rsp_valid_out,
  output logic [DATA_WIDTH-1:0]                rsp_data_out
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [NUM_REQ-1:0] PRIO_MASK = NUM_REQ'(1) << PRIO_REQ;
  logic [NUM_REQ-1:0] others, starved, s_gnt, r_gnt, gnt;
  logic [PW-1:0] s_idx, r_idx, gnt_idx, ptr_q, ptr_d;
  logic s_found, r_found, prio_vld;
  logic [NUM_REQ-1:0][WW-1:0] wait_q, wait_d;
  logic [READ_LATENCY:0][NUM_REQ-1:0] tag_q;
  assign others = req_valid_in & ~PRIO_MASK;
  assign prio_vld = req_valid_in[PRIO_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wait
    assign starved[i] = others[i] && wait_q[i] == WW'(MAX_WAIT);
    assign wait_d[i] = (i == PRIO_REQ || !req_valid_in[i] || gnt[i]) ? '0 :
                       (wait_q[i] == WW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + 1'b1;
  end
  // Both searches share the RR pointer; PRIO_REQ is masked out of both.
  rr_picker #(.N(NUM_REQ), .PW(PW)) u_starved (
    .req_i(starved), .ptr_i(ptr_q), .gnt_o(s_gnt), .idx_o(s_idx), .found_o(s_found)
  );
  rr_picker #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req_i(others), .ptr_i(ptr_q), .gnt_o(r_gnt), .idx_o(r_idx), .found_o(r_found)
  );
  always_comb begin
    gnt = !rst_in ? '0 : s_found ? s_gnt : prio_vld ? PRIO_MASK : r_gnt;
    gnt_idx = s_found ? s_idx : prio_vld ? PW'(PRIO_REQ) : r_idx;
    ptr_d = (s_found || (!prio_vld && r_found)) ? gnt_idx : ptr_q;
  end
  assign req_ready_out = gnt;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_q <= PW'(NUM_REQ - 1);
      wait_q <= '0;
      tag_q <= '0;
      mem_en_out <= 1'b0;
      mem_addr_out <= '0;
      rsp_valid_out <= '0;
      rsp_data_out <= '0;
    end else begin
      ptr_q <= ptr_d;
      wait_q <= wait_d;
      tag_q <= {tag_q[READ_LATENCY-1:0], gnt};
      mem_en_out <= |gnt;
      if (|gnt) mem_addr_out <= req_addr_in[gnt_idx];
      rsp_valid_out <= tag_q[READ_LATENCY];
      if (|tag_q[READ_LATENCY]) rsp_data_out <= mem_data_in;
    end
  end
endmodule
